// File: rtl/riscv_pkg.sv
// Shared RV64I core constants and types used by the register file slice.
package riscv_pkg;

    // Native integer width of the core.
    localparam int XLEN = 64;

    // Architectural integer register count (x0..x31).
    localparam int NUM_ARCH_REGS = 32;

    // Architectural register index.
    typedef logic [4:0] reg_addr_t;

    // True when an address names a real (writable, trackable) register.
    function automatic logic is_real_reg(input logic [31:0] addr);
        return addr != 32'd0;
    endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Bundle of read, write, alloc and flush signals between issue/writeback and
// the multi-port register file. master = pipeline side, slave = register file.
//
// Handshake: there is no valid/ready pair here. Every request is a one-cycle
// strobe (wr_en, alloc_en, flush) qualified by its address/data in the same
// cycle; reads are combinational and always accepted.
interface regfile_mp_sb_if
    import riscv_pkg::*;
#(
    parameter int XLEN     = riscv_pkg::XLEN,
    parameter int NUM_REGS = NUM_ARCH_REGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD-1:0][AW-1:0]   rd_addr;
    logic [NUM_RD-1:0][XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]           rd_busy;
    logic [NUM_WR-1:0]           wr_en;
    logic [NUM_WR-1:0][AW-1:0]   wr_addr;
    logic [NUM_WR-1:0][XLEN-1:0] wr_data;
    logic                        alloc_en;
    logic [AW-1:0]               alloc_addr;
    logic                        flush;
    logic                        any_busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
        input  rd_data, rd_busy, any_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
        output rd_data, rd_busy, any_busy
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for in-flight destination registers.
// Priority per edge: flush clears everything, otherwise alloc beats a write
// clear to the same register (the write belongs to an older instruction).
// Bit 0 (x0) is never set.
module regfile_scoreboard
    import riscv_pkg::*;
#(
    parameter int NUM_REGS = NUM_ARCH_REGS,
    parameter int NUM_WR   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_WR-1:0]         wr_en,
    input  logic [NUM_WR-1:0][AW-1:0] wr_addr,
    input  logic                      alloc_en,
    input  logic [AW-1:0]             alloc_addr,
    input  logic                      flush,
    output logic [NUM_REGS-1:0]       busy,
    output logic                      any_busy
);

    logic [NUM_REGS-1:0] busy_next;

    // Next busy vector: clear on writeback, then set on alloc, flush overrides.
    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && wr_addr[j] != '0) begin
                    busy_next[wr_addr[j]] = 1'b0;
                end
            end
            if (alloc_en && alloc_addr != '0) begin
                busy_next[alloc_addr] = 1'b1;
            end
        end
        busy_next[0] = 1'b0;
    end

    // Busy-bit state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign any_busy = |busy[NUM_REGS-1:1];

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with integrated busy-bit scoreboard.
// N combinational read ports, M synchronous write ports (highest index wins
// on address conflict), x0 hardwired to zero and never busy.
// Optional macro REGFILE_BYPASS_EN: same-cycle write data (and cleared busy
// bit) is forwarded to read ports; without it writes are visible next cycle.
module regfile_mp_sb
    import riscv_pkg::*;
#(
    parameter int XLEN     = riscv_pkg::XLEN,
    parameter int NUM_REGS = NUM_ARCH_REGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_mp_sb_if.slave        bus
);

    logic [XLEN-1:0]             regs [NUM_REGS];
    logic [NUM_REGS-1:0]         busy;
    logic [NUM_RD-1:0][XLEN-1:0] rd_data_c;
    logic [NUM_RD-1:0]           rd_busy_c;
    logic                        any_busy_c;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (bus.wr_en),
        .wr_addr    (bus.wr_addr),
        .alloc_en   (bus.alloc_en),
        .alloc_addr (bus.alloc_addr),
        .flush      (bus.flush),
        .busy       (busy),
        .any_busy   (any_busy_c)
    );

    // Data array: later (higher-index) ports overwrite earlier ones on conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.wr_en[j] && bus.wr_addr[j] != '0) begin
                    regs[bus.wr_addr[j]] <= bus.wr_data[j];
                end
            end
        end
    end

    // Read muxes: stored state, optionally overridden by same-cycle writes.
    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (bus.rd_addr[i] != '0) begin
                rd_data_c[i] = regs[bus.rd_addr[i]];
                rd_busy_c[i] = busy[bus.rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
                // Ascending scan so the highest-index matching port wins.
                for (int j = 0; j < NUM_WR; j++) begin
                    if (bus.wr_en[j] && bus.wr_addr[j] == bus.rd_addr[i]) begin
                        rd_data_c[i] = bus.wr_data[j];
                        rd_busy_c[i] = bus.alloc_en && (bus.alloc_addr == bus.rd_addr[i]);
                    end
                end
`endif
            end
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.any_busy = any_busy_c;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb (two write ports).
// Expected values depend on whether REGFILE_BYPASS_EN is defined.
module tb_regfile_mp_sb;
    import riscv_pkg::*;

    localparam int XLEN     = 64;
    localparam int NUM_REGS = 32;
    localparam int NUM_RD   = 2;
    localparam int NUM_WR   = 2;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_pass;

    logic [XLEN-1:0] exp_q[$];

    regfile_mp_sb_if #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
    ) bus ();

    regfile_mp_sb #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.wr_en      = '0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.alloc_en   = 1'b0;
        bus.alloc_addr = '0;
        bus.flush      = 1'b0;
    endtask

    // Advance one cycle; returns at the falling edge with inputs cleared.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    task automatic wr(input int port, input reg_addr_t a, input logic [XLEN-1:0] d);
        bus.wr_en[port]   = 1'b1;
        bus.wr_addr[port] = a;
        bus.wr_data[port] = d;
    endtask

    task automatic alloc(input reg_addr_t a);
        bus.alloc_en   = 1'b1;
        bus.alloc_addr = a;
    endtask

    // Set both read addresses and let combinational reads settle.
    task automatic rd(input reg_addr_t a0, input reg_addr_t a1);
        bus.rd_addr[0] = a0;
        bus.rd_addr[1] = a1;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.rd_addr = '0;
        idle();

        // Reset state
        rd(5'd5, 5'd0);
        check("reset_rd_x5", bus.rd_data[0], 64'h0);
        check("reset_busy_x5", {63'b0, bus.rd_busy[0]}, 64'h0);
        check("reset_any_busy", {63'b0, bus.any_busy}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Write x5, alloc x6, then asynchronous reset mid-run
        wr(0, 5'd5, 64'hDEAD);
        alloc(5'd6);
        step();
        rd(5'd5, 5'd6);
        check("x5_written", bus.rd_data[0], 64'hDEAD);
        check("x6_busy", {63'b0, bus.rd_busy[1]}, 64'h1);
        check("any_busy_set", {63'b0, bus.any_busy}, 64'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_x5", bus.rd_data[0], 64'h0);
        check("async_rst_any_busy", {63'b0, bus.any_busy}, 64'h0);
        step();
        rst_n = 1'b1;
        step();
        rd(5'd5, 5'd6);
        check("post_rst_x5", bus.rd_data[0], 64'h0);
        check("post_rst_x6_busy", {63'b0, bus.rd_busy[1]}, 64'h0);
        check("post_rst_any_busy", {63'b0, bus.any_busy}, 64'h0);

        // x0: writes and allocs ignored
        wr(0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        alloc(5'd0);
        rd(5'd0, 5'd0);
        check("x0_same_cycle", bus.rd_data[0], 64'h0);
        step();
        rd(5'd0, 5'd0);
        check("x0_data", bus.rd_data[0], 64'h0);
        check("x0_busy", {63'b0, bus.rd_busy[0]}, 64'h0);
        check("x0_any_busy", {63'b0, bus.any_busy}, 64'h0);

        // Write-port conflict: port1 wins
        wr(0, 5'd7, 64'h11);
        wr(1, 5'd7, 64'h22);
        step();
        rd(5'd7, 5'd7);
        check("conflict_x7", bus.rd_data[1], 64'h22);

        // Scoreboard set / clear / alloc-beats-write
        alloc(5'd3);
        step();
        rd(5'd3, 5'd0);
        check("x3_busy_c1", {63'b0, bus.rd_busy[0]}, 64'h1);
        step();
        step();
        step();
        rd(5'd3, 5'd0);
        check("x3_busy_c4", {63'b0, bus.rd_busy[0]}, 64'h1);
        wr(0, 5'd3, 64'h55);
        step();
        rd(5'd3, 5'd0);
        check("x3_busy_cleared", {63'b0, bus.rd_busy[0]}, 64'h0);
        check("x3_data_55", bus.rd_data[0], 64'h55);
        check("any_busy_clear", {63'b0, bus.any_busy}, 64'h0);
        alloc(5'd3);
        wr(1, 5'd3, 64'h66);
        step();
        rd(5'd3, 5'd0);
        check("x3_alloc_wins_busy", {63'b0, bus.rd_busy[0]}, 64'h1);
        check("x3_alloc_wins_data", bus.rd_data[0], 64'h66);
        wr(0, 5'd3, 64'h66);
        step();

        // Flush beats alloc; data untouched, same-cycle writes still land
        alloc(5'd1);
        step();
        alloc(5'd2);
        step();
        alloc(5'd9);
        step();
        rd(5'd1, 5'd9);
        check("flush_pre_any_busy", {63'b0, bus.any_busy}, 64'h1);
        check("flush_pre_x9_busy", {63'b0, bus.rd_busy[1]}, 64'h1);
        bus.flush = 1'b1;
        alloc(5'd4);
        wr(0, 5'd12, 64'h77);
        step();
        rd(5'd4, 5'd1);
        check("flush_any_busy", {63'b0, bus.any_busy}, 64'h0);
        check("flush_x4_busy", {63'b0, bus.rd_busy[0]}, 64'h0);
        check("flush_x1_busy", {63'b0, bus.rd_busy[1]}, 64'h0);
        rd(5'd7, 5'd12);
        check("flush_x7_data", bus.rd_data[0], 64'h22);
        check("flush_x12_write", bus.rd_data[1], 64'h77);

        // Bypass behaviour on x10 (initially 0, made busy first)
        alloc(5'd10);
        step();
        wr(1, 5'd10, 64'hABCD);
        rd(5'd10, 5'd10);
`ifdef REGFILE_BYPASS_EN
        check("bypass_x10_data", bus.rd_data[0], 64'hABCD);
        check("bypass_x10_busy", {63'b0, bus.rd_busy[0]}, 64'h0);
        alloc(5'd10);
        #1;
        check("bypass_x10_busy_alloc", {63'b0, bus.rd_busy[1]}, 64'h1);
`else
        check("nobypass_x10_data", bus.rd_data[0], 64'h0);
        check("nobypass_x10_busy", {63'b0, bus.rd_busy[0]}, 64'h1);
`endif
        step();
        rd(5'd10, 5'd0);
        check("x10_after_edge", bus.rd_data[0], 64'hABCD);

        // Multi-register readback through both ports
        for (int k = 0; k < 4; k += 2) begin
            wr(0, reg_addr_t'(20 + k), 64'h1000 + 64'(k));
            wr(1, reg_addr_t'(21 + k), 64'h2000 + 64'(k + 1));
            exp_q.push_back(64'h1000 + 64'(k));
            exp_q.push_back(64'h2000 + 64'(k + 1));
            step();
        end
        for (int k = 0; k < 4; k += 2) begin
            logic [XLEN-1:0] e0;
            logic [XLEN-1:0] e1;
            rd(reg_addr_t'(20 + k), reg_addr_t'(21 + k));
            e0 = exp_q.pop_front();
            e1 = exp_q.pop_front();
            check("readback_port0", bus.rd_data[0], e0);
            check("readback_port1", bus.rd_data[1], e1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file for the RV64I/Zba core, generalised from the single-issue 2R1W file. Supports N read ports, M write ports, an optional same-cycle write-to-read bypass, and an integrated busy-bit scoreboard for in-flight destination registers. Sits between decode/issue (read and alloc) and writeback (write and clear).

Parameters:
XLEN, 64, data width of each register
NUM_REGS, 32, architectural register count, power of two, at least 2
NUM_RD, 2, number of read ports
NUM_WR, 1, number of write ports
AW, $clog2(NUM_REGS), address width (derived; do not override)

Ports:
clk  in  1  core clock
rst_n  in  1  reset
rd_addr  in  NUM_RD x AW  read addresses
rd_data  out  NUM_RD x XLEN  read data
rd_busy  out  NUM_RD  scoreboard busy bit of rd_addr[i]
wr_en  in  NUM_WR  write enables
wr_addr  in  NUM_WR x AW  write addresses
wr_data  in  NUM_WR x XLEN  write data
alloc_en  in  1  mark alloc_addr busy (issue of a writing instruction)
alloc_addr  in  AW  destination being allocated
flush  in  1  clear all busy bits (pipeline flush)
any_busy  out  1  OR of all busy bits

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset: all registers 1..NUM_REGS-1 are set to 0 and all busy bits to 0. Consequently rd_data = 0, rd_busy = 0 and any_busy = 0 during and after reset, until the first write or alloc.
- Register x0: reads always return 0 and rd_busy = 0. Writes and allocs to x0 are ignored.
- Read path: rd_data[i] and rd_busy[i] are combinational from rd_addr[i] (zero latency).
- Write path: synchronous. wr_data[j] is stored on the rising clk edge when wr_en[j] = 1 and wr_addr[j] != 0.
- Write conflicts: if several enabled write ports target the same address in one cycle, the highest-index port wins. No error is flagged.
- Scoreboard set: alloc_en = 1 and alloc_addr != 0 sets busy[alloc_addr] on the next edge.
- Scoreboard clear: any enabled write to address a clears busy[a] on the next edge.
- Alloc and write to the same register in the same cycle: alloc wins and busy stays 1, because the write belongs to the older instruction. The data is still written.
- Flush: flush = 1 clears all busy bits on the next edge and takes priority over alloc. Register contents are not affected, and writes in the same cycle still update data.
- Flush and reset: flush does not reset data. An rst_n assertion mid-operation immediately zeroes all state asynchronously.
- any_busy: registered-state OR of busy[1..NUM_REGS-1], combinational from current state.
- Read of a register written this cycle, without bypass: returns the old value and the old busy bit.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: if an enabled write port targets rd_addr[i] (nonzero) in the current cycle, rd_data[i] returns that port's wr_data, using the highest-index port on conflict. In the same case rd_busy[i] = 0 unless alloc_en targets the same address this cycle.
- Undefined: reads reflect stored state only, with one cycle of write-to-read latency.

Decomposition:
- riscv_pkg: XLEN constant, NUM_ARCH_REGS = 32, and the typedef reg_addr_t = logic [4:0].
- Sub-module regfile_scoreboard: holds the busy-bit vector with its alloc/clear/flush priority logic and any_busy. It takes wr_en/wr_addr as clear inputs and is instantiated once.
- Data array, read muxes and bypass stay in the top level.

Test Plan:
- Reset: assert rst_n = 0 mid-run after writing x5 = 0xDEAD -> rd_data for x5 reads 0 immediately, any_busy = 0, and both hold after release.
- x0: write x0 = 0xFFFF_FFFF_FFFF_FFFF and alloc x0 -> read x0 returns 0, rd_busy = 0, any_busy = 0.
- Conflict: with NUM_WR = 2, write x7 from port0 = 0x11 and port1 = 0x22 in the same cycle -> next cycle x7 = 0x22.
- Scoreboard: alloc x3 in cycle 0 -> rd_busy(x3) = 1 from cycle 1. Write x3 = 0x55 in cycle 4 -> busy = 0 and data = 0x55 in cycle 5. Alloc plus write to x3 in the same cycle -> busy stays 1 and data is updated.
- Flush: alloc x1, x2, x9 -> any_busy = 1. Assert flush together with alloc x4 -> next cycle all busy = 0 and x4 is not busy; data is unchanged.
- Bypass (REGFILE_BYPASS_EN defined / undefined): write x10 = 0xABCD while reading x10 in the same cycle -> 0xABCD when defined, previous value (0) when undefined.
